// File: rtl/trade_pkg.sv
// Shared types and constants for the trade order path.
// Contents: order FSM state enum, order side enum, default widths and the
// order payload struct used between the order controller and its consumers.
package trade_pkg;

  localparam int unsigned TRADE_DATA_WIDTH = 16;
  localparam int unsigned TRADE_POS_WIDTH  = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    COOLDOWN = 2'd2
  } order_state_e;

  typedef enum logic {
    SELL = 1'b0,
    BUY  = 1'b1
  } order_side_e;

  typedef struct packed {
    order_side_e                 side;
    logic [TRADE_DATA_WIDTH-1:0] price;
    logic [TRADE_POS_WIDTH-1:0]  qty;
  } trade_order_t;

endpackage

// File: rtl/trade_pos_limit_chk.sv
// Combinational signed position-limit check.
// Ports:
//   position : current signed net position
//   buy_ok   : position + ORDER_QTY <= POS_LIMIT
//   sell_ok  : position - ORDER_QTY >= -POS_LIMIT
// Arithmetic is done one bit wider than the position to avoid overflow.
module trade_pos_limit_chk
  import trade_pkg::*;
#(
  parameter int unsigned POS_WIDTH = TRADE_POS_WIDTH,
  parameter int unsigned ORDER_QTY = 1,
  parameter int unsigned POS_LIMIT = 8
) (
  input  logic signed [POS_WIDTH-1:0] position,
  output logic                        buy_ok,
  output logic                        sell_ok
);

  localparam int unsigned EXT_W = POS_WIDTH + 1;
  localparam logic signed [EXT_W-1:0] QTY_S = EXT_W'(ORDER_QTY);
  localparam logic signed [EXT_W-1:0] LIM_S = EXT_W'(POS_LIMIT);

  logic signed [EXT_W-1:0] pos_ext;

  always_comb begin
    pos_ext = {position[POS_WIDTH-1], position};
    buy_ok  = (pos_ext + QTY_S) <= LIM_S;
    sell_ok = (pos_ext - QTY_S) >= -LIM_S;
  end

endmodule

// File: rtl/trade_order_ctrl.sv
// Turns buy/sell decisions from the mean-reversion signal stage into single
// handshaked orders for the trade logic unit, tracking net position, a
// symmetric position limit, a post-fill cooldown and an acceptance timeout.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   enable                : 0 blocks new orders (in-flight order still finishes)
//   data_valid_mean       : buy_signal/sell_signal/price valid
//   buy_signal/sell_signal: trade requests (both set = conflict, dropped)
//   price                 : price attached to the request
//   order_valid/ready     : order handshake with the TLU
//   order_side/price/qty  : order payload (side 1=buy), held while valid
//   position              : signed net position
//   busy                  : controller not idle
//   drop_pulse            : a valid request was not turned into an order
//   timeout_pulse         : order withdrawn after TIMEOUT_CYCLES without ready
// Build option: define TRADE_ORDER_STATS_EN to add saturating 32-bit
// stat_filled / stat_dropped / stat_timeout event counters.
module trade_order_ctrl
  import trade_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = TRADE_DATA_WIDTH,
  parameter int unsigned POS_WIDTH       = TRADE_POS_WIDTH,
  parameter int unsigned ORDER_QTY       = 1,
  parameter int unsigned POS_LIMIT       = 8,
  parameter int unsigned COOLDOWN_CYCLES = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        data_valid_mean,
  input  logic                        buy_signal,
  input  logic                        sell_signal,
  input  logic [DATA_WIDTH-1:0]       price,
  output logic                        order_valid,
  input  logic                        order_ready,
  output logic                        order_side,
  output logic [DATA_WIDTH-1:0]       order_price,
  output logic [POS_WIDTH-1:0]        order_qty,
  output logic signed [POS_WIDTH-1:0] position,
  output logic                        busy,
  output logic                        drop_pulse,
  output logic                        timeout_pulse
`ifdef TRADE_ORDER_STATS_EN
  ,
  output logic [31:0]                 stat_filled,
  output logic [31:0]                 stat_dropped,
  output logic [31:0]                 stat_timeout
`endif
);

  localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > COOLDOWN_CYCLES) ?
                                    TIMEOUT_CYCLES : COOLDOWN_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic signed [POS_WIDTH-1:0] QTY_S = POS_WIDTH'(ORDER_QTY);

  order_state_e                state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        side_d;
  logic [DATA_WIDTH-1:0]       price_d;
  logic signed [POS_WIDTH-1:0] pos_d;
  logic                        drop_d;
  logic                        tmo_d;
  logic                        fill_c;
  logic                        buy_ok, sell_ok;
  logic                        cand_c, sig_evt_c, accept_c, lim_ok_c;

  trade_pos_limit_chk #(
    .POS_WIDTH (POS_WIDTH),
    .ORDER_QTY (ORDER_QTY),
    .POS_LIMIT (POS_LIMIT)
  ) u_limit (
    .position (position),
    .buy_ok   (buy_ok),
    .sell_ok  (sell_ok)
  );

  // Request classification: any valid signal is an event; exactly one is a candidate.
  always_comb begin
    cand_c    = data_valid_mean && (buy_signal ^ sell_signal);
    sig_evt_c = data_valid_mean && (buy_signal | sell_signal);
    lim_ok_c  = buy_signal ? buy_ok : sell_ok;
    accept_c  = cand_c && enable && lim_ok_c && (state_q == IDLE);
  end

  // Next-state, counter and payload logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    side_d  = order_side;
    price_d = order_price;
    pos_d   = position;
    drop_d  = sig_evt_c && !accept_c;
    tmo_d   = 1'b0;
    fill_c  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          side_d  = buy_signal;
          price_d = price;
          cnt_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // Ready on the expiring cycle still wins over the timeout.
        if (order_ready) begin
          fill_c = 1'b1;
          pos_d  = order_side ? (position + QTY_S) : (position - QTY_S);
          if (COOLDOWN_CYCLES == 0) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            state_d = COOLDOWN;
            cnt_d   = CNT_W'(COOLDOWN_CYCLES);
          end
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          tmo_d   = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      COOLDOWN: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      order_valid   <= 1'b0;
      order_side    <= 1'b0;
      order_price   <= '0;
      order_qty     <= '0;
      position      <= '0;
      busy          <= 1'b0;
      drop_pulse    <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      order_valid   <= (state_d == ISSUE);
      order_side    <= side_d;
      order_price   <= price_d;
      order_qty     <= (state_d == ISSUE) ? POS_WIDTH'(ORDER_QTY) : '0;
      position      <= pos_d;
      busy          <= (state_d != IDLE);
      drop_pulse    <= drop_d;
      timeout_pulse <= tmo_d;
    end
  end

`ifdef TRADE_ORDER_STATS_EN
  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_filled  <= '0;
      stat_dropped <= '0;
      stat_timeout <= '0;
    end else begin
      if (fill_c && (stat_filled != '1))  stat_filled  <= stat_filled + 32'd1;
      if (drop_d && (stat_dropped != '1)) stat_dropped <= stat_dropped + 32'd1;
      if (tmo_d && (stat_timeout != '1))  stat_timeout <= stat_timeout + 32'd1;
    end
  end
`else
  logic unused_fill_c;
  assign unused_fill_c = fill_c;
`endif

endmodule

// File: doc/trade_order_ctrl.md
Name: trade_order_ctrl

Overview:
- Sequences raw buy/sell decisions from the mean-reversion signal stage into single, handshaked orders for the downstream trade logic unit (TLU).
- Tracks a signed net position, enforces a symmetric position limit and a post-trade cooldown, and withdraws orders the TLU does not accept within a timeout.
- Sits between the signal generator (buy/sell/valid, registered one cycle after price data) and the TLU order port.

Parameters:
- DATA_WIDTH, 16, price width (matches signal stage data_width)
- POS_WIDTH, 16, signed net-position width
- ORDER_QTY, 1, fixed quantity per order
- POS_LIMIT, 8, max absolute net position
- COOLDOWN_CYCLES, 4, idle cycles after a filled order (0 allowed)
- TIMEOUT_CYCLES, 16, max cycles order_valid is held without order_ready (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  trading enable; 0 blocks new orders, an order in flight still completes or times out
- data_valid_mean  in  1  buy_signal/sell_signal/price valid this cycle
- buy_signal  in  1  buy request
- sell_signal  in  1  sell request
- price  in  DATA_WIDTH  price associated with the signal
- order_valid  out  1  order presented to TLU
- order_ready  in  1  TLU accepts order
- order_side  out  1  1=buy, 0=sell
- order_price  out  DATA_WIDTH  order price
- order_qty  out  POS_WIDTH  always ORDER_QTY while valid
- position  out  POS_WIDTH  signed net position
- busy  out  1  state != IDLE
- drop_pulse  out  1  one-cycle pulse: valid signal not converted to an order
- timeout_pulse  out  1  one-cycle pulse: order withdrawn on timeout

Behaviour:
- Reset is rst, synchronous, active-high, on clock clk. All outputs reset to 0, position=0, state=IDLE, counters=0. Asserting rst mid-order drops the order immediately; no position update.
- FSM states: IDLE, ISSUE, COOLDOWN.
- Candidate event: data_valid_mean && (buy_signal ^ sell_signal).
- IDLE:
  - Candidate && enable && limit OK -> latch side/price, go to ISSUE. order_valid rises on the next cycle (1-cycle latency from data_valid_mean).
  - Limit OK means buy: position+ORDER_QTY <= POS_LIMIT; sell: position-ORDER_QTY >= -POS_LIMIT. Compare in signed arithmetic, POS_WIDTH+1 bits to avoid overflow.
- ISSUE:
  - order_valid=1; side, price and qty held stable.
  - order_valid && order_ready at an edge -> position += or -= ORDER_QTY on the same edge. Go to COOLDOWN (load COOLDOWN_CYCLES), or to IDLE if COOLDOWN_CYCLES==0.
  - Timeout counter increments each cycle without ready. At TIMEOUT_CYCLES with no ready -> deassert order_valid, timeout_pulse=1 for one cycle, go to IDLE, no position change.
  - The TLU contract explicitly permits this withdrawal. Ready in the same cycle the count expires counts as accepted.
- COOLDOWN: counts down; leaving it takes exactly COOLDOWN_CYCLES cycles, then IDLE. A candidate in the cycle IDLE is re-entered is eligible.
- drop_pulse (registered, 1 cycle later) fires for a valid event that is not accepted:
  - buy && sell both set (conflict)
  - limit violation
  - enable=0
  - state != IDLE
- data_valid_mean=0 -> signals ignored, no drop.
- busy = (state != IDLE).

Optional Feature:
- TRADE_ORDER_STATS_EN
- Defined: adds outputs stat_filled, stat_dropped, stat_timeout (each 32-bit). They count fills, drop_pulse and timeout_pulse events, saturate at all-ones, and clear on rst.
- Undefined: ports and counters absent; core behaviour identical.

Decomposition:
- Shared package trade_pkg holds:
  - typedef order_state_e {IDLE, ISSUE, COOLDOWN}
  - typedef order_side_e (SELL=0, BUY=1)
  - DATA_WIDTH default constant
  - typedef trade_order_t {side, price, qty}
- One natural sub-module: trade_pos_limit_chk, a combinational signed limit check returning buy_ok and sell_ok from position, ORDER_QTY and POS_LIMIT.
- The FSM and the cooldown/timeout counter stay in the top.

Test Plan:
- Buy, ready tied high, price=100 at cycle t -> order_valid at t+1 with side=1 and price=100. position=1 after t+1. busy through COOLDOWN (4 cycles), then IDLE.
- 9 buys spaced past cooldown, ready high -> 8 fills, position=8. Ninth buy gives drop_pulse=1 and no order_valid. A following sell fills, position=7.
- order_ready held 0 -> order_valid high for exactly 16 cycles, then timeout_pulse for 1 cycle, position unchanged. Ready asserted on cycle 16 -> fill, no timeout.
- buy and sell both 1 with data_valid_mean -> drop_pulse, no order. Buy with enable=0 -> drop_pulse. Buy during ISSUE or COOLDOWN -> drop_pulse, in-flight order unaffected.
- rst asserted while order_valid=1 and ready=0 -> next cycle order_valid=0, position=0, busy=0. Re-issue after rst works.
- With TRADE_ORDER_STATS_EN: 3 fills, 2 drops, 1 timeout -> stat_filled=3, stat_dropped=2, stat_timeout=1.
